// File: rtl/rtc_write_sequencer.sv
// RTC write sequencer: snapshots time/date fields on start, writes them one bus cycle
// per field to RTC RAM, then issues the RAM-to-clock/timer transfer command.
module rtc_write_sequencer #(
  parameter logic [7:0] A_SEG_CLK = 8'h21,
  parameter logic [7:0] A_SEG_TMR = 8'h41,
  parameter logic [7:0] A_DIA     = 8'h24,
  parameter logic [7:0] A_CMD     = 8'hF0,
  parameter logic [7:0] CMD_DATA  = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       en_clk,
  input  logic       dir_phase,
  input  logic       dat_phase,
  input  logic       step_done,
  input  logic [7:0] seg_in,
  input  logic [7:0] min_in,
  input  logic [7:0] hora_in,
  input  logic [7:0] dia_in,
  input  logic [7:0] mes_in,
  input  logic [7:0] ano_in,
  output logic [7:0] ad_out,
  output logic       wr_req,
  output logic       busy,
  output logic [2:0] field,
  output logic       write_done
);

  // W_* encodings equal the field index; IDLE sits outside 0..6 so it never aliases a field.
  typedef enum logic [3:0] {
    W_SEG  = 4'd0,
    W_MIN  = 4'd1,
    W_HORA = 4'd2,
    W_DIA  = 4'd3,
    W_MES  = 4'd4,
    W_ANO  = 4'd5,
    W_CMD  = 4'd6,
    IDLE   = 4'd8
  } state_t;

  state_t     state_reg;
  state_t     step_next;
  logic       en_clk_reg;
  logic       capture;
  logic [7:0] data_in  [6];
  logic [7:0] snap_val [6];
  logic [7:0] sel_addr;
  logic [7:0] sel_data;

  assign data_in[0] = seg_in;
  assign data_in[1] = min_in;
  assign data_in[2] = hora_in;
  assign data_in[3] = dia_in;
  assign data_in[4] = mes_in;
  assign data_in[5] = ano_in;

  assign capture = (state_reg == IDLE) && start;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_snap
      logic [7:0] q_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)        q_reg <= '0;
        else if (capture) q_reg <= data_in[gi];
      end
      assign snap_val[gi] = q_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        en_clk_reg <= 1'b0;
    else if (capture) en_clk_reg <= en_clk;
  end

  always_comb begin
    sel_addr = 8'hFF;
    sel_data = 8'hFF;
    case (state_reg)
      W_SEG:  begin sel_addr = en_clk_reg ? A_SEG_CLK : A_SEG_TMR;                 sel_data = snap_val[0]; end
      W_MIN:  begin sel_addr = en_clk_reg ? A_SEG_CLK + 8'd1 : A_SEG_TMR + 8'd1;   sel_data = snap_val[1]; end
      W_HORA: begin sel_addr = en_clk_reg ? A_SEG_CLK + 8'd2 : A_SEG_TMR + 8'd2;   sel_data = snap_val[2]; end
      W_DIA:  begin sel_addr = A_DIA;                                              sel_data = snap_val[3]; end
      W_MES:  begin sel_addr = A_DIA + 8'd1;                                       sel_data = snap_val[4]; end
      W_ANO:  begin sel_addr = A_DIA + 8'd2;                                       sel_data = snap_val[5]; end
      W_CMD:  begin sel_addr = {A_CMD[7:4], en_clk_reg ? 4'h1 : 4'h2};             sel_data = CMD_DATA;    end
      default: ;
    endcase
  end

  // Timer target has no date fields, so it jumps from hours straight to the command.
  always_comb begin
    step_next = IDLE;
    case (state_reg)
      W_SEG:   step_next = W_MIN;
      W_MIN:   step_next = W_HORA;
      W_HORA:  step_next = en_clk_reg ? W_DIA : W_CMD;
      W_DIA:   step_next = W_MES;
      W_MES:   step_next = W_ANO;
      W_ANO:   step_next = W_CMD;
      default: step_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      ad_out     <= 8'hFF;
      wr_req     <= 1'b0;
      busy       <= 1'b0;
      field      <= 3'd0;
      write_done <= 1'b0;
    end else begin
      write_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          ad_out <= 8'hFF;
          field  <= 3'd0;
          wr_req <= start;
          busy   <= start;
          if (start) state_reg <= W_SEG;
        end
        W_SEG, W_MIN, W_HORA, W_DIA, W_MES, W_ANO, W_CMD: begin
          if (dir_phase) begin
            ad_out <= sel_addr;
          end else if (dat_phase) begin
            ad_out <= sel_data;
          end else if (step_done) begin
            if (state_reg == W_CMD) begin
              state_reg  <= IDLE;
              ad_out     <= 8'hFF;
              wr_req     <= 1'b0;
              busy       <= 1'b0;
              field      <= 3'd0;
              write_done <= 1'b1;
            end else begin
              state_reg <= step_next;
              field     <= 3'(step_next);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          ad_out    <= 8'hFF;
          wr_req    <= 1'b0;
          busy      <= 1'b0;
          field     <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Scoreboard bench for rtc_write_sequencer: stimulus pushes expected bus bytes and
// completion markers; a monitor pops and compares whenever the DUT presents them.
module tb_rtc_write_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       en_clk = 1'b0;
  logic       dir_phase = 1'b0;
  logic       dat_phase = 1'b0;
  logic       step_done = 1'b0;
  logic [7:0] seg_in = 8'h00, min_in = 8'h00, hora_in = 8'h00;
  logic [7:0] dia_in = 8'h00, mes_in = 8'h00, ano_in = 8'h00;
  logic [7:0] ad_out;
  logic       wr_req, busy, write_done;
  logic [2:0] field;

  rtc_write_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .en_clk(en_clk),
    .dir_phase(dir_phase), .dat_phase(dat_phase), .step_done(step_done),
    .seg_in(seg_in), .min_in(min_in), .hora_in(hora_in),
    .dia_in(dia_in), .mes_in(mes_in), .ano_in(ano_in),
    .ad_out(ad_out), .wr_req(wr_req), .busy(busy), .field(field),
    .write_done(write_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [7:0] val;
    logic [2:0] fld;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  logic pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // A phase strobe seen at a rising edge means ad_out is valid at the following falling edge.
  always @(posedge clk) pend <= (dir_phase | dat_phase) & ~reset;

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (pend || write_done)) begin
      if (exp_q.size() == 0) begin
        chk(pend ? "unexpected_byte" : "unexpected_done", {24'd0, ad_out}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        if (write_done) begin
          n_done++;
          chk("done_marker", {31'd0, e.is_done}, 32'd1);
          chk("done_ad_ff", {24'd0, ad_out}, 32'h0000_00FF);
          chk("done_busy_wr_low", {30'd0, busy, wr_req}, 32'd0);
        end else begin
          chk("byte_not_done", {31'd0, e.is_done}, 32'd0);
          chk("ad_byte", {24'd0, ad_out}, {24'd0, e.val});
          chk("byte_field", {29'd0, field}, {29'd0, e.fld});
          $display("byte ad_out=%02h expected=%02h field=%0d", ad_out, e.val, field);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] v, input logic [2:0] f);
    exp_t e;
    e.is_done = 1'b0; e.val = v; e.fld = f;
    exp_q.push_back(e);
  endtask

  task automatic bus_cycle(input logic [7:0] a, input logic [7:0] d, input logic [2:0] f);
    exp_t e;
    push_byte(a, f);
    push_byte(d, f);
    if (f == 3'd6) begin
      e.is_done = 1'b1; e.val = 8'hFF; e.fld = 3'd0;
      exp_q.push_back(e);
    end
    @(negedge clk) dir_phase = 1'b1;
    @(negedge clk) begin dir_phase = 1'b0; dat_phase = 1'b1; end
    @(negedge clk) begin dat_phase = 1'b0; step_done = 1'b1; end
    @(negedge clk) step_done = 1'b0;
  endtask

  task automatic set_inputs(input logic [7:0] s, m, h, di, me, an);
    seg_in = s; min_in = m; hora_in = h; dia_in = di; mes_in = me; ano_in = an;
  endtask

  task automatic start_seq(input logic en);
    @(negedge clk) begin start = 1'b1; en_clk = en; end
    @(negedge clk) start = 1'b0;
  endtask

  task automatic clock_seq(input logic [7:0] s, m, h, di, me, an);
    bus_cycle(8'h21, s, 3'd0);
    bus_cycle(8'h22, m, 3'd1);
    bus_cycle(8'h23, h, 3'd2);
    bus_cycle(8'h24, di, 3'd3);
    bus_cycle(8'h25, me, 3'd4);
    bus_cycle(8'h26, an, 3'd5);
    bus_cycle(8'hF1, 8'h01, 3'd6);
  endtask

  initial begin
    int budget;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ad_out", {24'd0, ad_out}, 32'h0000_00FF);
    chk("rst_busy_wr", {30'd0, busy, wr_req}, 32'd0);
    chk("rst_field", {29'd0, field}, 32'd0);
    chk("rst_done", {31'd0, write_done}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Clock write with a 20-cycle stall in W_HORA
    set_inputs(8'h59, 8'h45, 8'h23, 8'h31, 8'h12, 8'h99);
    start_seq(1'b1);
    chk("start_busy_wr", {30'd0, busy, wr_req}, 32'd3);
    bus_cycle(8'h21, 8'h59, 3'd0);
    bus_cycle(8'h22, 8'h45, 3'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_ad_out", {24'd0, ad_out}, 32'h0000_0045);
      chk("stall_wr_busy", {30'd0, busy, wr_req}, 32'd3);
      chk("stall_field", {29'd0, field}, 32'd2);
    end
    bus_cycle(8'h23, 8'h23, 3'd2);
    bus_cycle(8'h24, 8'h31, 3'd3);
    bus_cycle(8'h25, 8'h12, 3'd4);
    bus_cycle(8'h26, 8'h99, 3'd5);
    bus_cycle(8'hF1, 8'h01, 3'd6);
    $display("clock write sequence issued");

    // Timer write: four bus cycles, date addresses never appear
    set_inputs(8'h10, 8'h20, 8'h03, 8'h77, 8'h77, 8'h77);
    start_seq(1'b0);
    bus_cycle(8'h41, 8'h10, 3'd0);
    bus_cycle(8'h42, 8'h20, 3'd1);
    bus_cycle(8'h43, 8'h03, 3'd2);
    bus_cycle(8'hF2, 8'h01, 3'd6);
    $display("timer write sequence issued");

    // Snapshot isolation plus start re-asserted during W_MIN
    set_inputs(8'h59, 8'h45, 8'h23, 8'h31, 8'h12, 8'h99);
    start_seq(1'b1);
    @(negedge clk) seg_in = 8'h00;
    bus_cycle(8'h21, 8'h59, 3'd0);
    @(negedge clk) begin start = 1'b1; en_clk = 1'b0; end
    @(negedge clk) start = 1'b0;
    chk("restart_field", {29'd0, field}, 32'd1);
    bus_cycle(8'h22, 8'h45, 3'd1);
    bus_cycle(8'h23, 8'h23, 3'd2);
    bus_cycle(8'h24, 8'h31, 3'd3);
    bus_cycle(8'h25, 8'h12, 3'd4);
    bus_cycle(8'h26, 8'h99, 3'd5);
    bus_cycle(8'hF1, 8'h01, 3'd6);
    repeat (2) @(negedge clk);
    chk("idle_after_restart", {30'd0, busy, wr_req}, 32'd0);
    $display("snapshot/restart sequence issued");

    // Reset asserted in W_DIA aborts without a command cycle
    set_inputs(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    start_seq(1'b1);
    bus_cycle(8'h21, 8'h11, 3'd0);
    bus_cycle(8'h22, 8'h22, 3'd1);
    bus_cycle(8'h23, 8'h33, 3'd2);
    push_byte(8'h24, 3'd3);
    @(negedge clk) dir_phase = 1'b1;
    @(negedge clk) dir_phase = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_ad_out", {24'd0, ad_out}, 32'h0000_00FF);
    chk("abort_busy_wr", {30'd0, busy, wr_req}, 32'd0);
    chk("abort_field", {29'd0, field}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_abort_ad_out", {24'd0, ad_out}, 32'h0000_00FF);
      chk("post_abort_idle", {29'd0, busy, wr_req, write_done}, 32'd0);
    end
    set_inputs(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    start_seq(1'b1);
    clock_seq(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    $display("post-reset full sequence issued");

    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("queue_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    chk("write_done_count", n_done, 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
